// File: rtl/stepper_pkg.sv
// Shared types for the stepper phase sequencer: drive modes, FSM states, mode decode.
package stepper_pkg;

  typedef enum logic [1:0] {
    WAVE = 2'b00,
    FULL = 2'b01,
    HALF = 2'b10,
    RSVD = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The reserved encoding behaves as full-step.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return WAVE;
      2'b10:   return HALF;
      default: return FULL;
    endcase
  endfunction

endpackage

// File: rtl/stepper_phase_seq_if.sv
// Command/status bundle between the motion control FSM and the phase sequencer.
interface stepper_phase_seq_if #(
  parameter int PHASES = 4,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
);
  logic              cs;
  logic              start;
  logic [1:0]        mode;
  logic              dir;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  steps;
  logic              abort;
  logic              busy;
  logic              done;
  logic              step_pulse;
  logic [CNT_W-1:0]  remaining;
  logic [PHASES-1:0] phase_out;

  modport master (
    output cs, start, mode, dir, div, steps, abort,
    input  busy, done, step_pulse, remaining, phase_out
  );

  modport slave (
    input  cs, start, mode, dir, div, steps, abort,
    output busy, done, step_pulse, remaining, phase_out
  );
endinterface

// File: rtl/stepper_pattern.sv
// Combinational map from half-step position index to coil pattern.
// Even index k energises coil k/2; odd index k energises coils k/2 and k/2+1 (mod PHASES).
module stepper_pattern #(
  parameter int PHASES = 4,
  parameter int IDX_W  = $clog2(2 * PHASES)
) (
  input  logic [IDX_W-1:0]  index,
  output logic [PHASES-1:0] pattern
);

  // Decode each coil's contribution to the pattern.
  always_comb begin
    pattern = '0;
    for (int unsigned p = 0; p < PHASES; p++) begin
      if (index == IDX_W'(2 * p)) begin
        pattern[p] = 1'b1;
      end
      if (index == IDX_W'(2 * p + 1)) begin
        pattern[p]                = 1'b1;
        pattern[(p + 1) % PHASES] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stepper_phase_seq.sv
// Multi-phase stepper coil sequencer: run FSM, step-rate divider, step counter,
// half-step position index and registered coil outputs.
module stepper_phase_seq
  import stepper_pkg::*;
#(
  parameter int PHASES = 4,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                reset,
  stepper_phase_seq_if.slave bus
);

  localparam int             IDX_W  = $clog2(2 * PHASES);
  localparam logic [IDX_W:0] NPOS_W = (IDX_W + 1)'(2 * PHASES);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d, mode_new;
  logic               dir_q, dir_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_step;
  logic [IDX_W:0]     idx_sum, step_inc;
  logic               energ_q, energ_d;
  logic               done_q, done_d;
  logic               pulse_q, pulse_d;
  logic [PHASES-1:0]  phase_q, phase_d, pat;

  stepper_pattern #(
    .PHASES (PHASES),
    .IDX_W  (IDX_W)
  ) u_pattern (
    .index   (idx_q),
    .pattern (pat)
  );

  // Next position one step along, wrapping modulo 2*PHASES in either direction.
  // Reverse adds (2*PHASES - inc) so a single conditional subtract handles both wraps.
  always_comb begin
    step_inc = (mode_q == HALF) ? (IDX_W + 1)'(1) : (IDX_W + 1)'(2);
    idx_sum  = {1'b0, idx_q} + (dir_q ? step_inc : (NPOS_W - step_inc));
    if (idx_sum >= NPOS_W) begin
      idx_sum = idx_sum - NPOS_W;
    end
    idx_step = idx_sum[IDX_W-1:0];
  end

  // Run FSM, divider, step counter and output pattern next-state.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    div_d    = div_q;
    tick_d   = tick_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    energ_d  = energ_q;
    done_d   = 1'b0;
    pulse_d  = 1'b0;
    mode_new = decode_mode(bus.mode);
    phase_d  = (bus.cs && energ_q) ? pat : '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d = bus.steps;
          if (bus.steps == '0) begin
            done_d = 1'b1;
          end else begin
            mode_d  = mode_new;
            dir_d   = bus.dir;
            div_d   = bus.div;
            tick_d  = '0;
            energ_d = 1'b1;
            state_d = RUN;
            case (mode_new)
              WAVE:    idx_d = {idx_q[IDX_W-1:1], 1'b0};
              FULL:    idx_d = {idx_q[IDX_W-1:1], 1'b1};
              default: idx_d = idx_q;
            endcase
          end
        end
      end
      RUN: begin
        if (tick_q == div_q) begin
          idx_d   = idx_step;
          pulse_d = 1'b1;
          rem_d   = rem_q - 1'b1;
          tick_d  = '0;
          if ((rem_q == CNT_W'(1)) || bus.abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
          if (bus.abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= WAVE;
      dir_q   <= 1'b0;
      div_q   <= '0;
      tick_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      energ_q <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      energ_q <= energ_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      phase_q <= phase_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = done_q;
  assign bus.step_pulse = pulse_q;
  assign bus.remaining  = rem_q;
  assign bus.phase_out  = phase_q;

endmodule

// File: tb/tb_stepper_phase_seq.sv
// Scoreboard bench for stepper_phase_seq with PHASES=4.
module tb_stepper_phase_seq;

  typedef struct {
    logic [3:0]  pat;
    logic [15:0] rem;
    logic        last;
    int unsigned gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  stepper_phase_seq_if #(.PHASES(4), .DIV_W(16), .CNT_W(16)) bus ();

  stepper_phase_seq #(.PHASES(4), .DIV_W(16), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Half-step patterns for 4 coils, position 0..7.
  logic [3:0]  tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                           4'b0100, 4'b1100, 4'b1000, 4'b1001};
  exp_t        exp_q[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned m_idx = 0;
  int unsigned m_align = 0;
  bit          phase_chk_en = 1'b1;
  logic [3:0]  last_pat = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: pop an expected step on every step_pulse; check pattern a cycle later.
  bit          pend = 1'b0;
  logic [3:0]  pend_pat = '0;
  logic        busy_prev = 1'b0;
  int unsigned gap = 0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      busy_prev = 1'b0;
      gap = 0;
    end else begin
      if (pend && phase_chk_en) check_eq("step_phase", bus.phase_out, pend_pat);
      pend = 1'b0;
      if (bus.busy && !busy_prev) gap = 0;
      else gap++;
      busy_prev = bus.busy;
      if (bus.step_pulse) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_step", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("step_rem", bus.remaining, mon_e.rem);
          check_eq("step_done", bus.done, mon_e.last);
          check_eq("step_gap", gap, mon_e.gap);
          pend = 1'b1;
          pend_pat = mon_e.pat;
          last_pat = mon_e.pat;
        end
        gap = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.cs = 1'b0; bus.start = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0;
    bus.div = '0; bus.steps = '0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.cs = 1'b1;
    exp_q.delete();
    m_idx = 0;
  endtask

  // Issue a start and push the expected step sequence from the position model.
  task automatic run_cmd(input logic [1:0] m, input logic d, input logic [15:0] dv, input logic [15:0] n);
    int unsigned idx, inc, em;
    exp_t e;
    em = (m == 2'b11) ? 1 : int'(m);
    idx = m_idx;
    if (n != 0) begin
      if (em == 0) idx = idx & ~32'd1;
      else if (em == 1) idx = idx | 32'd1;
      m_align = idx;
      inc = (em == 2) ? 1 : 2;
      for (int unsigned i = 1; i <= n; i++) begin
        idx = d ? (idx + inc) % 8 : (idx + 8 - inc) % 8;
        e.pat = tbl[idx];
        e.rem = 16'(n - i);
        e.last = (i == n);
        e.gap = dv + 1;
        exp_q.push_back(e);
      end
      m_idx = idx;
    end
    bus.mode = m; bus.dir = d; bus.div = dv; bus.steps = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (n != 0 && dv != 0 && phase_chk_en) begin
      @(negedge clk);
      check_eq("align_phase", bus.phase_out, tbl[m_align]);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_seen", bus.done, 1);
    check_eq("done_busy", bus.busy, 0);
    @(negedge clk);
    check_eq("done_single", bus.done, 0);
  endtask

  task automatic wait_pulses(input int cnt, input int budget);
    int k = 0;
    int c = 0;
    while (c < cnt && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.step_pulse) c++;
    end
    check_eq("pulse_wait", c, cnt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and idle with cs=1 but no start.
    bus.cs = 1'b0; bus.start = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0;
    bus.div = '0; bus.steps = '0; bus.abort = 1'b0;
    @(negedge clk);
    check_eq("rst_phase", bus.phase_out, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_pulse", bus.step_pulse, 0);
    check_eq("rst_rem", bus.remaining, 0);
    do_reset();
    repeat (16) @(negedge clk);
    check_eq("idle_phase", bus.phase_out, 0);
    check_eq("idle_busy", bus.busy, 0);

    // HALF reverse from index 0, div=0: wraps 0 -> 7.
    run_cmd(2'b10, 1'b0, 16'd0, 16'd9);
    wait_done(40);

    // FULL forward, div=3, 4 steps; then reserved mode acting as FULL reverse.
    do_reset();
    run_cmd(2'b01, 1'b1, 16'd3, 16'd4);
    wait_done(40);
    run_cmd(2'b11, 1'b0, 16'd1, 16'd3);
    wait_done(40);

    // Zero-step start: done next cycle, nothing moves.
    run_cmd(2'b00, 1'b1, 16'd2, 16'd0);
    check_eq("zero_done", bus.done, 1);
    check_eq("zero_busy", bus.busy, 0);
    check_eq("zero_pulse", bus.step_pulse, 0);
    check_eq("zero_phase", bus.phase_out, tbl[m_idx]);
    @(negedge clk);
    check_eq("zero_done_end", bus.done, 0);
    check_eq("zero_phase_hold", bus.phase_out, tbl[m_idx]);

    // Start while busy is ignored.
    run_cmd(2'b00, 1'b1, 16'd2, 16'd5);
    wait_pulses(1, 20);
    bus.mode = 2'b10; bus.dir = 1'b0; bus.div = 16'd0; bus.steps = 16'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("restart_busy", bus.busy, 1);
    wait_done(40);

    // WAVE forward 100 steps, abort after the 10th step.
    do_reset();
    run_cmd(2'b00, 1'b1, 16'd3, 16'd100);
    wait_pulses(10, 100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_done", bus.done, 1);
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_rem", bus.remaining, 90);
    check_eq("abort_pulse", bus.step_pulse, 0);
    exp_q.delete();
    m_idx = (m_align + 20) % 8;
    repeat (3) @(negedge clk);
    check_eq("abort_hold", bus.phase_out, 4'b0100);
    check_eq("abort_done_end", bus.done, 0);
    // Abort while idle does nothing.
    bus.abort = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_abort_busy", bus.busy, 0);
    check_eq("idle_abort_done", bus.done, 0);
    bus.abort = 1'b0;

    // Abort coincident with the final tick: step issued, single done.
    run_cmd(2'b10, 1'b1, 16'd2, 16'd3);
    wait_pulses(2, 20);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("coinc_pulse", bus.step_pulse, 1);
    check_eq("coinc_done", bus.done, 1);
    @(negedge clk);
    check_eq("coinc_single", bus.done, 0);
    @(negedge clk);
    check_eq("coinc_drained", exp_q.size(), 0);

    // cs dropped mid-run blanks coils while stepping continues; reset mid-run clears at once.
    phase_chk_en = 1'b0;
    run_cmd(2'b10, 1'b1, 16'd3, 16'd12);
    wait_pulses(3, 40);
    bus.cs = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("cs_off_phase", bus.phase_out, 0);
    check_eq("cs_off_busy", bus.busy, 1);
    bus.cs = 1'b1;
    @(negedge clk);
    check_eq("cs_on_phase", bus.phase_out, last_pat);
    phase_chk_en = 1'b1;
    wait_pulses(2, 40);
    #1 reset = 1'b1;
    #1;
    check_eq("mrst_busy", bus.busy, 0);
    check_eq("mrst_done", bus.done, 0);
    check_eq("mrst_pulse", bus.step_pulse, 0);
    check_eq("mrst_rem", bus.remaining, 0);
    check_eq("mrst_phase", bus.phase_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_idx = 0;
    repeat (3) @(negedge clk);
    check_eq("mrst_deenerg", bus.phase_out, 0);
    check_eq("mrst_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
